aes_iter_core: RTL and testbench

//  Iterative AES engine, one round per clock: AES-128/192/256, encrypt or decrypt selected per request.

---
 rtl/aes_pkg.sv | 98 +++++++++
 rtl/aes_round_key_sel.sv | 19 +
 rtl/aes_iter_core.sv | 105 ++++++++++
 tb/tb_aes_iter_core.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM encoding and GF(2^8)/AES step functions for the iterative AES core
package aes_pkg;
  localparam int BLOCK_W = 128;
  typedef enum logic [1:0] {KL_128 = 2'b00, KL_192 = 2'b01, KL_256 = 2'b10, KL_RSV = 2'b11} key_len_e;
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_DONE} fsm_e;
  typedef logic [59:0][31:0] sched_t;
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return kl == KL_192 ? 4'd12 : kl == KL_256 ? 4'd14 : 4'd10;
  endfunction
  function automatic int nk_of(input logic [1:0] kl);
    return kl == KL_192 ? 6 : kl == KL_256 ? 8 : 4;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, y;
    x2 = gmul(x, x);
    x3 = gmul(x2, x);
    x12 = gmul(x3, x3);
    x12 = gmul(x12, x12);
    y = gmul(x12, x3);
    for (int i = 0; i < 4; i++) y = gmul(y, y);
    y = gmul(y, x12);
    return gmul(y, x2);
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [7:0] bget(input logic [127:0] s, input int k);
    return s[127-8*k -: 8];
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv ? inv_sbox(bget(s, k)) : sbox(bget(s, k));
    return o;
  endfunction
  // byte 4c+r sits in column c, row r; row r rotates left by r (right when inverting)
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = bget(s, 4*((inv ? c + 4 - r : c + r) % 4) + r);
    return o;
  endfunction
  // circulant column multiply: {02,03,01,01} forward, {0e,0b,0d,09} inverse
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [3:0][7:0] m;
    logic [7:0] acc;
    m = inv ? {8'h0e, 8'h0b, 8'h0d, 8'h09} : {8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[3-((j-r+4)%4)], bget(s, 4*c+j));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction
  // full word schedule for an Nk-word key taken from the top of the 256-bit key field
  function automatic sched_t key_expand(input logic [255:0] key, input int nk);
    sched_t w;
    logic [31:0] t;
    logic [7:0] rc;
    w = '0;
    rc = 8'h01;
    for (int i = 0; i < 60; i++)
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    return w;
  endfunction
endpackage

// File: rtl/aes_round_key_sel.sv
// aes_round_key_sel: expands the registered key for all three key lengths and returns round key idx
module aes_round_key_sel
  import aes_pkg::*;
(
  input  logic [255:0] key,
  input  logic [1:0]   key_len,
  input  logic [3:0]   idx,
  output logic [127:0] rk
);
  sched_t sch [3];
  sched_t sel;
  logic [5:0] base;
  for (genvar g = 0; g < 3; g++) begin : g_exp
    assign sch[g] = key_expand(key, nk_of(2'(g)));
  end
  assign sel = sch[key_len == KL_RSV ? 2'd0 : key_len];
  assign base = {idx, 2'b00};
  assign rk = {sel[base], sel[base+6'd1], sel[base+6'd2], sel[base+6'd3]};
endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 encrypt/decrypt engine, one round per clock
// ports: in_valid/in_ready request with key_len, decrypt, key, data_in;
//        out_valid/out_ready response with data_out, out_err; busy, round_cnt, state_lsb for progress display
module aes_iter_core
  import aes_pkg::*;
#(
  parameter bit ENABLE_DEC = 1'b1,
  parameter int KEY_W      = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         key_len,
  input  logic               decrypt,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic               out_err,
  output logic               busy,
  output logic [3:0]         round_cnt,
  output logic [7:0]         state_lsb
);
  fsm_e fsm_q, fsm_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [1:0] kl_q, kl_d;
  logic dec_q, dec_d, err_q, err_d;
  logic [3:0] nr_q, nr_d, rnd_q, rnd_d, rk_idx;
  logic [BLOCK_W-1:0] st_q, st_d, rk, enc_t, enc_rnd, dec_t, dec_rnd;
  logic accept, illegal, dec_en, last;
  assign in_ready = fsm_q == S_IDLE && !reset;
  assign accept = in_valid && in_ready;
  assign illegal = key_len == KL_RSV || (decrypt && !ENABLE_DEC);
  assign dec_en = dec_q && ENABLE_DEC;
  assign last = rnd_q == nr_q;
  assign rk_idx = fsm_q == S_INIT ? (dec_en ? nr_q : 4'd0) : (dec_en ? nr_q - rnd_q : rnd_q);
  aes_round_key_sel u_rk (.key(key_q), .key_len(kl_q), .idx(rk_idx), .rk(rk));
  assign enc_t = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
  assign enc_rnd = (last ? enc_t : mix_columns(enc_t, 1'b0)) ^ rk;
  assign dec_t = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk;
  assign dec_rnd = last ? dec_t : mix_columns(dec_t, 1'b1);
  always_comb begin
    fsm_d = fsm_q;
    key_d = key_q;
    kl_d = kl_q;
    dec_d = dec_q;
    nr_d = nr_q;
    rnd_d = rnd_q;
    st_d = st_q;
    err_d = err_q;
    case (fsm_q)
      S_IDLE: if (accept) begin
        key_d = key;
        kl_d = key_len;
        dec_d = decrypt;
        nr_d = nr_of(key_len);
        rnd_d = 4'd0;
        err_d = illegal;
        st_d = illegal ? '0 : data_in;
        fsm_d = illegal ? S_DONE : S_INIT;
      end
      S_INIT: begin
        st_d = st_q ^ rk;
        rnd_d = 4'd1;
        fsm_d = S_ROUND;
      end
      S_ROUND: begin
        st_d = dec_en ? dec_rnd : enc_rnd;
        rnd_d = last ? rnd_q : rnd_q + 4'd1;
        fsm_d = last ? S_DONE : S_ROUND;
      end
      S_DONE: fsm_d = out_ready ? S_IDLE : S_DONE;
      default: fsm_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= S_IDLE;
      key_q <= '0;
      kl_q <= '0;
      dec_q <= 1'b0;
      nr_q <= '0;
      rnd_q <= '0;
      st_q <= '0;
      err_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      key_q <= key_d;
      kl_q <= kl_d;
      dec_q <= dec_d;
      nr_q <= nr_d;
      rnd_q <= rnd_d;
      st_q <= st_d;
      err_q <= err_d;
    end
  end
  assign out_valid = fsm_q == S_DONE;
  assign out_err = out_valid && err_q;
  assign data_out = out_valid ? st_q : '0;
  assign busy = fsm_q == S_INIT || fsm_q == S_ROUND;
  assign round_cnt = rnd_q;
  assign state_lsb = st_q[7:0];
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: scoreboard bench for aes_iter_core using FIPS-197 vectors
module tb_aes_iter_core;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hc3c3c3c3c3c3c3c3};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  typedef struct packed {logic [127:0] d; logic err; int lat; logic [3:0] rc;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic clk = 0, reset = 1, in_valid = 0, decrypt = 0, out_ready = 0, nd_valid = 0, nd_ready = 0;
  logic [1:0] key_len = 0;
  logic [255:0] key = '0;
  logic [127:0] data_in = '0;
  logic in_ready, out_valid, out_err, busy;
  logic [127:0] data_out;
  logic [3:0] round_cnt;
  logic [7:0] state_lsb;
  logic nd_in_ready, nd_out_valid, nd_out_err, nd_busy;
  logic [127:0] nd_data_out;
  logic [3:0] nd_round_cnt;
  logic [7:0] nd_state_lsb;
  aes_iter_core dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .key_len(key_len),
    .decrypt(decrypt), .key(key), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_err(out_err), .busy(busy), .round_cnt(round_cnt), .state_lsb(state_lsb));
  aes_iter_core #(.ENABLE_DEC(1'b0)) dut_nd (.clk(clk), .reset(reset), .in_valid(nd_valid), .in_ready(nd_in_ready),
    .key_len(key_len), .decrypt(decrypt), .key(key), .data_in(data_in), .out_valid(nd_out_valid),
    .out_ready(nd_ready), .data_out(nd_data_out), .out_err(nd_out_err), .busy(nd_busy),
    .round_cnt(nd_round_cnt), .state_lsb(nd_state_lsb));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input logic [1:0] kl, input logic dec, input logic [255:0] k, input logic [127:0] d,
                     input logic [127:0] xd, input logic xe, input int lat, input logic [3:0] rc, input logic hold);
    exp_t e;
    @(negedge clk);
    key_len = kl;
    decrypt = dec;
    key = k;
    data_in = d;
    in_valid = 1;
    e = '{d: xd, err: xe, lat: lat, rc: rc};
    sb.push_back(e);
    check("req_rdy", in_ready, 1);
    @(posedge clk);
    #1 if (!hold) in_valid = 0;
  endtask
  task automatic wait_out(input string tag);
    exp_t e;
    int n = 1;
    e = '0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      check({tag, "_rdy_busy"}, in_ready, 0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_lat"}, n, e.lat);
    check({tag, "_data"}, data_out, e.d);
    check({tag, "_err"}, out_err, e.err);
    check({tag, "_rcnt"}, round_cnt, e.rc);
    check({tag, "_lsb"}, state_lsb, e.d[7:0]);
    check({tag, "_busy"}, busy, 0);
  endtask
  task automatic ack();
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  task automatic run(input string tag, input logic [1:0] kl, input logic dec, input logic [255:0] k,
                     input logic [127:0] d, input logic [127:0] xd, input logic xe, input int lat,
                     input logic [3:0] rc, input logic early);
    out_ready = early;
    req(kl, dec, k, d, xd, xe, lat, rc, 1'b0);
    wait_out(tag);
    ack();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    check("rst_round_cnt", round_cnt, 0);
    check("rst_state_lsb", state_lsb, 0);
    reset = 0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    run("enc128", 2'b00, 0, K128, PT, CT128, 0, 12, 10, 0);
    run("enc192", 2'b01, 0, K192, PT, CT192, 0, 14, 12, 0);
    run("dec192", 2'b01, 1, K192, CT192, PT, 0, 14, 12, 1);
    run("dec256", 2'b10, 1, K256, CT256, PT, 0, 16, 14, 0);
    run("enc256", 2'b10, 0, K256, PT, CT256, 0, 16, 14, 0);
    run("dec128", 2'b00, 1, K128, CT128, PT, 0, 12, 10, 1);
    req(2'b00, 0, K128, PT, CT128, 0, 12, 10, 1);
    key_len = 2'b01;
    decrypt = 1;
    key = K192;
    data_in = CT192;
    wait_out("bp_a");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_data", data_out, CT128);
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_rdy", in_ready, 0);
    end
    ack();
    req(2'b01, 1, K192, CT192, PT, 0, 14, 12, 0);
    wait_out("bp_b");
    ack();
    req(2'b00, 0, K128, PT, CT128, 0, 12, 10, 0);
    t = 0;
    while (round_cnt != 4'd5 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("mid_rcnt", round_cnt, 5);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    void'(sb.pop_back());
    @(negedge clk);
    check("mid_in_ready", in_ready, 1);
    check("mid_busy", busy, 0);
    check("mid_rcnt0", round_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("mid_no_vld", out_valid, 0);
    end
    run("after_rst", 2'b00, 0, K128, PT, CT128, 0, 12, 10, 0);
    run("kl11_enc", 2'b11, 0, K128, PT, '0, 1, 1, 0, 0);
    run("kl11_dec", 2'b11, 1, K256, CT256, '0, 1, 1, 0, 1);
    run("post_err", 2'b10, 0, K256, PT, CT256, 0, 16, 14, 0);
    @(negedge clk);
    key_len = 2'b00;
    decrypt = 1;
    key = K128;
    data_in = CT128;
    nd_valid = 1;
    check("nd_rdy", nd_in_ready, 1);
    @(posedge clk);
    #1 nd_valid = 0;
    @(negedge clk);
    check("nd_vld", nd_out_valid, 1);
    check("nd_err", nd_out_err, 1);
    check("nd_data", nd_data_out, 0);
    check("nd_rcnt", nd_round_cnt, 0);
    nd_ready = 1;
    @(posedge clk);
    #1 nd_ready = 0;
    @(negedge clk);
    check("nd_idle_rdy", nd_in_ready, 1);
    check("nd_idle_vld", nd_out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
